// File: rtl/rx_align_pkg.sv
// Shared types and constants for the receive word aligner.
package rx_align_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StSlip,
        StWait,
        StLocked,
        StError
    } align_state_e;

    localparam logic [7:0] DefaultTrainPattern = 8'hC5;

    // Width of the total slip counter (saturates at all-ones).
    localparam int unsigned SlipCntW = 4;

    // Per-orientation slip counter and the slip limit within one orientation.
    localparam int unsigned                OrientCntW    = 3;
    localparam logic [OrientCntW-1:0]      OrientSlipMax = 3'd7;

endpackage

// File: rtl/rx_align_pattern_cmp.sv
// Combinational training-word compare with optional 8-bit reversal of the input word.
module rx_align_pattern_cmp
    import rx_align_pkg::*;
#(
    parameter logic [7:0] PATTERN = DefaultTrainPattern
) (
    input  logic [7:0] data,
    input  logic       rev,
    output logic       match
);

    logic [7:0] data_rev;

    // Bit-reverse the word (bit 0 <-> bit 7, ...).
    always_comb begin
        data_rev = '0;
        for (int i = 0; i < 8; i++) begin
            data_rev[i] = data[7-i];
        end
    end

    assign match = ((rev ? data_rev : data) == PATTERN);

endmodule

// File: rtl/rx_word_align_ctrl.sv
// Receive lane word aligner: compares deserialized words against a training pattern and
// issues single-cycle bitslip pulses until enough consecutive valid matches give lock.
// Build option: define RX_WORD_ALIGN_REV_SEARCH_EN to retry every slip position against
// the bit-reversed word once the normal orientation is exhausted.
module rx_word_align_ctrl
    import rx_align_pkg::*;
#(
    parameter logic [7:0]  TRAIN_PATTERN = DefaultTrainPattern,
    parameter int unsigned MATCH_COUNT   = 16,
    parameter int unsigned SLIP_WAIT     = 4
) (
    input  logic                SCLK,
    input  logic                RESET,
    input  logic                TRAIN_START,
    input  logic [7:0]          RX_DATA,
    input  logic                RX_VALID,
    output logic                BITSLIP,
    output logic                ALIGN_DONE,
    output logic                ALIGN_ERR,
    output logic [SlipCntW-1:0] SLIP_CNT,
    output logic                REV_SEL
);

    align_state_e          state_q, state_d;
    logic [7:0]            match_cnt_q;
    logic [OrientCntW-1:0] orient_cnt_q;
    logic [SlipCntW-1:0]   slip_cnt_q;
    logic [3:0]            wait_cnt_q;
    logic                  rev_q;
    logic                  rev_switch_q;
    logic                  word_match;
    logic                  rev_search_ok;
    logic                  orient_done;
    logic                  last_match;

    rx_align_pattern_cmp #(
        .PATTERN (TRAIN_PATTERN)
    ) u_cmp (
        .data  (RX_DATA),
        .rev   (rev_q),
        .match (word_match)
    );

`ifdef RX_WORD_ALIGN_REV_SEARCH_EN
    assign rev_search_ok = ~rev_q;
`else
    assign rev_search_ok = 1'b0;
`endif

    assign orient_done = (orient_cnt_q == OrientSlipMax);
    assign last_match  = (match_cnt_q == 8'(MATCH_COUNT - 1));

    // State register.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; TRAIN_START overrides whatever the current state decided.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: ;
            StCompare: begin
                if (RX_VALID) begin
                    if (word_match) begin
                        if (last_match) state_d = StLocked;
                    end else if (!orient_done || rev_search_ok) begin
                        state_d = StSlip;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StSlip:   state_d = StWait;
            StWait:   if (wait_cnt_q == 4'd0) state_d = StCompare;
            StLocked: ;
            StError:  ;
            default:  state_d = StIdle;
        endcase
        if (TRAIN_START) state_d = StCompare;
    end

    // Match, slip and settle counters plus compare orientation.
    // The slip that switches orientation does not count toward the new orientation, so
    // the reversed orientation gets its own full set of seven slips.
    always_ff @(posedge SCLK) begin
        if (RESET || TRAIN_START) begin
            match_cnt_q  <= '0;
            orient_cnt_q <= '0;
            slip_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            rev_q        <= 1'b0;
            rev_switch_q <= 1'b0;
        end else begin
            case (state_q)
                StCompare: begin
                    if (RX_VALID) begin
                        if (word_match) begin
                            match_cnt_q <= match_cnt_q + 8'd1;
                        end else begin
                            match_cnt_q <= '0;
                            if (orient_done && rev_search_ok) begin
                                rev_q        <= 1'b1;
                                orient_cnt_q <= '0;
                                rev_switch_q <= 1'b1;
                            end
                        end
                    end
                end
                StSlip: begin
                    if (rev_switch_q) begin
                        rev_switch_q <= 1'b0;
                    end else begin
                        orient_cnt_q <= orient_cnt_q + 3'd1;
                    end
                    if (slip_cnt_q != '1) slip_cnt_q <= slip_cnt_q + 4'd1;
                    wait_cnt_q <= 4'(SLIP_WAIT - 1);
                end
                StWait: begin
                    if (wait_cnt_q != 4'd0) wait_cnt_q <= wait_cnt_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        BITSLIP    = (state_q == StSlip);
        ALIGN_DONE = (state_q == StLocked);
        ALIGN_ERR  = (state_q == StError);
        SLIP_CNT   = slip_cnt_q;
        REV_SEL    = rev_q;
    end

endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// Self-checking bench for rx_word_align_ctrl with a rotating-lane model and a
// slip-count predictor derived from the alignment rules.
module tb_rx_word_align_ctrl;

    localparam logic [7:0] PAT = 8'hC5;
    localparam int         MC  = 16;
    localparam int         SW  = 4;
`ifdef RX_WORD_ALIGN_REV_SEARCH_EN
    localparam bit RevEn = 1'b1;
`else
    localparam bit RevEn = 1'b0;
`endif

    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic       train_start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       bitslip, align_done, align_err, rev_sel;
    logic [3:0] slip_cnt;

    int checks = 0;
    int errors = 0;

    rx_word_align_ctrl #(
        .TRAIN_PATTERN (PAT),
        .MATCH_COUNT   (MC),
        .SLIP_WAIT     (SW)
    ) dut (
        .SCLK        (sclk),
        .RESET       (reset),
        .TRAIN_START (train_start),
        .RX_DATA     (rx_data),
        .RX_VALID    (rx_valid),
        .BITSLIP     (bitslip),
        .ALIGN_DONE  (align_done),
        .ALIGN_ERR   (align_err),
        .SLIP_CNT    (slip_cnt),
        .REV_SEL     (rev_sel)
    );

    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int r);
        logic [15:0] t;
        t = {w, w} << (r % 8);
        return t[15:8];
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[i] = w[7-i];
        return o;
    endfunction

    // Walk slip positions in order (normal orientation, then reversed if enabled) and
    // return how many slips precede the first position whose word equals the pattern.
    function automatic void predict(input logic [7:0] base, input int offset, input bit rotate,
                                    output int slips, output bit lock);
        int max_s;
        logic [7:0] w;
        max_s = RevEn ? 15 : 7;
        lock  = 1'b0;
        slips = max_s;
        for (int s = 0; s <= max_s; s++) begin
            w = rotl8(base, rotate ? offset + s : offset);
            if (s >= 8) w = rev8(w);
            if (!lock && w == PAT) begin
                lock  = 1'b1;
                slips = s;
            end
        end
    endfunction

    // Start training and drive a lane whose word rotates by one per observed BITSLIP.
    // Tracks when comparing is active and flags ALIGN_DONE deviating from the cycle
    // right after the MC-th consecutive valid match.
    task automatic run_lane(input logic [7:0] base, input int offset, input bit rotate,
                            input int gap_mode, input int inject_after,
                            output int pulses, output bit done_seen, output bit err_seen,
                            output int min_gap, output bit timing_ok, output bit excl_ok);
        int n = 0;
        int last = 0;
        int cmp_from = 0;
        int run = 0;
        int gap_left = 0;
        bit exp_done = 0;
        bit gap_done = 0;
        bit injected = 0;
        bit v;
        bit d = 0;
        bit e = 0;
        logic [7:0] w;
        min_gap   = 1000;
        timing_ok = 1'b1;
        excl_ok   = 1'b1;
        train_start = 1'b1;
        rx_valid    = 1'b1;
        rx_data     = rotl8(base, offset);
        step();
        train_start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !d && !e; cyc++) begin
            if (bitslip) begin
                if (n > 0 && cyc - last < min_gap) min_gap = cyc - last;
                last     = cyc;
                n++;
                cmp_from = cyc + SW + 1;
                run      = 0;
            end
            if (align_done !== exp_done) timing_ok = 1'b0;
            if (align_done && align_err) excl_ok = 1'b0;
            d = align_done;
            e = align_err;
            exp_done = 1'b0;
            if (gap_mode == 2 && run == 8 && !gap_done) begin
                gap_left = 5;
                gap_done = 1'b1;
            end
            if (gap_left > 0) begin
                v = 1'b0;
                gap_left--;
            end else if (gap_mode == 1) begin
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            w = rotl8(base, rotate ? offset + n : offset);
            if (inject_after > 0 && !injected && v && cyc >= cmp_from && run == inject_after) begin
                w = ~w;
                injected = 1'b1;
            end
            rx_valid = v;
            rx_data  = w;
            if (v && cyc >= cmp_from) begin
                if (((RevEn && n >= 8) ? rev8(w) : w) == PAT) begin
                    run++;
                    if (run == MC) exp_done = 1'b1;
                end else begin
                    run = 0;
                end
            end
            step();
        end
        pulses    = n;
        done_seen = d;
        err_seen  = e;
    endtask

    task automatic wait_pulse();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (bitslip) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_pulse: no BITSLIP within 50 cycles, expected one");
        end
    endtask

    task automatic test_reset();
        int seen_done = 0;
        reset = 1'b1;
        train_start = 1'b1;
        rx_valid = 1'b1;
        rx_data = PAT;
        repeat (3) step();
        checks += 5;
        if (bitslip !== 1'b0) begin errors++; $display("FAIL reset_bitslip: got %b expected 0", bitslip); end
        if (align_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", align_done); end
        if (align_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", align_err); end
        if (slip_cnt !== 4'd0) begin errors++; $display("FAIL reset_slip_cnt: got %0d expected 0", slip_cnt); end
        if (rev_sel !== 1'b0) begin errors++; $display("FAIL reset_rev_sel: got %b expected 0", rev_sel); end
        reset = 1'b0;
        train_start = 1'b0;
        repeat (25) begin
            step();
            if (align_done || bitslip) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL idle_no_start: got %0d active cycles expected 0", seen_done);
        end
    endtask

    task automatic test_aligned();
        int p, g;
        bit d, e, t, x;
        run_lane(PAT, 0, 1'b1, 0, 0, p, d, e, g, t, x);
        checks += 5;
        if (p != 0) begin errors++; $display("FAIL aligned_pulses: got %0d expected 0", p); end
        if (!d) begin errors++; $display("FAIL aligned_done: got %b expected 1", d); end
        if (!t) begin errors++; $display("FAIL aligned_done_timing: got late/early expected cycle after 16th match"); end
        if (slip_cnt !== 4'd0) begin errors++; $display("FAIL aligned_slip_cnt: got %0d expected 0", slip_cnt); end
        if (!x) begin errors++; $display("FAIL aligned_exclusive: got done&err expected never"); end
        rx_data = 8'h00;
        repeat (5) step();
        checks++;
        if (align_done !== 1'b1 || bitslip !== 1'b0) begin
            errors++;
            $display("FAIL locked_hold: got done=%b slip=%b expected done=1 slip=0", align_done, bitslip);
        end
    endtask

    task automatic test_rotated();
        int p, g;
        bit d, e, t, x;
        run_lane(PAT, 5, 1'b1, 0, 0, p, d, e, g, t, x);
        checks += 5;
        if (p != 3) begin errors++; $display("FAIL rotated_pulses: got %0d expected 3", p); end
        if (g != SW + 2) begin errors++; $display("FAIL rotated_spacing: got %0d expected %0d", g, SW + 2); end
        if (!d || !t) begin errors++; $display("FAIL rotated_lock: got done=%b timing=%b expected 1 1", d, t); end
        if (slip_cnt !== 4'd3) begin errors++; $display("FAIL rotated_slip_cnt: got %0d expected 3", slip_cnt); end
        if (rev_sel !== 1'b0) begin errors++; $display("FAIL rotated_rev_sel: got %b expected 0", rev_sel); end
    endtask

    task automatic test_exhaust();
        int p, g, es;
        bit d, e, t, x, el;
        predict(8'h00, 0, 1'b1, es, el);
        run_lane(8'h00, 0, 1'b1, 0, 0, p, d, e, g, t, x);
        checks += 6;
        if (p != es) begin errors++; $display("FAIL exhaust_pulses: got %0d expected %0d", p, es); end
        if (!e || d) begin errors++; $display("FAIL exhaust_err: got err=%b done=%b expected 1 0", e, d); end
        if (slip_cnt !== 4'(es)) begin errors++; $display("FAIL exhaust_slip_cnt: got %0d expected %0d", slip_cnt, es); end
        if (rev_sel !== RevEn) begin errors++; $display("FAIL exhaust_rev_sel: got %b expected %b", rev_sel, RevEn); end
        if (g != SW + 2) begin errors++; $display("FAIL exhaust_spacing: got %0d expected %0d", g, SW + 2); end
        if (!x) begin errors++; $display("FAIL exhaust_exclusive: got done&err expected never"); end
        rx_data = PAT;
        repeat (5) step();
        checks++;
        if (align_err !== 1'b1 || align_done !== 1'b0 || bitslip !== 1'b0) begin
            errors++;
            $display("FAIL error_hold: got err=%b done=%b slip=%b expected 1 0 0", align_err, align_done, bitslip);
        end
    endtask

    task automatic test_reverse();
        int p, g, es;
        bit d, e, t, x, el;
        predict(8'hA3, 0, 1'b1, es, el);
        run_lane(8'hA3, 0, 1'b1, 0, 0, p, d, e, g, t, x);
        checks += 4;
        if (p != es) begin errors++; $display("FAIL reverse_pulses: got %0d expected %0d", p, es); end
        if (d != el || e == el) begin errors++; $display("FAIL reverse_outcome: got done=%b err=%b expected lock=%b", d, e, el); end
        if (rev_sel !== RevEn) begin errors++; $display("FAIL reverse_rev_sel: got %b expected %b", rev_sel, RevEn); end
        if (!t) begin errors++; $display("FAIL reverse_done_timing: got wrong ALIGN_DONE cycle expected exact"); end
    endtask

    task automatic test_mismatch_inject();
        int p, g;
        bit d, e, t, x;
        run_lane(PAT, 0, 1'b0, 0, 10, p, d, e, g, t, x);
        checks += 3;
        if (p != 1) begin errors++; $display("FAIL inject_pulses: got %0d expected 1", p); end
        if (!d || !t) begin errors++; $display("FAIL inject_relock: got done=%b timing=%b expected 1 1", d, t); end
        if (slip_cnt !== 4'd1) begin errors++; $display("FAIL inject_slip_cnt: got %0d expected 1", slip_cnt); end
    endtask

    task automatic test_valid_gap();
        int p, g;
        bit d, e, t, x;
        run_lane(PAT, 0, 1'b1, 2, 0, p, d, e, g, t, x);
        checks += 2;
        if (p != 0) begin errors++; $display("FAIL gap_pulses: got %0d expected 0", p); end
        if (!d || !t) begin errors++; $display("FAIL gap_lock: got done=%b timing=%b expected 1 1", d, t); end
    endtask

    task automatic test_random();
        int p, g, es, off, gm;
        bit d, e, t, x, el;
        logic [7:0] base;
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 2))
                0:       base = PAT;
                1:       base = 8'hA3;
                default: base = 8'($urandom_range(0, 255));
            endcase
            off = $urandom_range(0, 7);
            gm  = $urandom_range(0, 1);
            predict(base, off, 1'b1, es, el);
            run_lane(base, off, 1'b1, gm, 0, p, d, e, g, t, x);
            checks += 5;
            if (p != es) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d (base %h off %0d)", it, p, es, base, off); end
            if (d != el || e == el) begin errors++; $display("FAIL rand_outcome[%0d]: got done=%b err=%b expected lock=%b", it, d, e, el); end
            if (slip_cnt !== 4'(es)) begin errors++; $display("FAIL rand_slip_cnt[%0d]: got %0d expected %0d", it, slip_cnt, es); end
            if (rev_sel !== (RevEn && es >= 8)) begin errors++; $display("FAIL rand_rev_sel[%0d]: got %b expected %b", it, rev_sel, RevEn && es >= 8); end
            if (!t || !x || (p >= 2 && g < SW + 2)) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got timing=%b excl=%b gap=%0d expected 1 1 >=%0d", it, t, x, g, SW + 2);
            end
        end
    endtask

    task automatic test_restart_in_wait();
        logic [7:0] bad;
        bad = rotl8(PAT, 5);
        train_start = 1'b1;
        rx_valid = 1'b1;
        rx_data = bad;
        step();
        train_start = 1'b0;
        wait_pulse();
        step();
        train_start = 1'b1;
        step();
        checks += 3;
        if (bitslip !== 1'b0) begin errors++; $display("FAIL restart_wait_bitslip: got %b expected 0", bitslip); end
        if (slip_cnt !== 4'd0) begin errors++; $display("FAIL restart_wait_slip_cnt: got %0d expected 0", slip_cnt); end
        if (align_done !== 1'b0 || align_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_wait_flags: got done=%b err=%b expected 0 0", align_done, align_err);
        end
        // Compare state with a mismatching word: TRAIN_START must suppress the slip.
        step();
        train_start = 1'b0;
        checks++;
        if (bitslip !== 1'b0) begin errors++; $display("FAIL restart_override: got %b expected 0", bitslip); end
        step();
        checks++;
        if (bitslip !== 1'b1) begin errors++; $display("FAIL restart_then_slip: got %b expected 1", bitslip); end
        step();
        checks++;
        if (slip_cnt !== 4'd1) begin errors++; $display("FAIL restart_slip_cnt: got %0d expected 1", slip_cnt); end
    endtask

    task automatic test_reset_in_slip();
        int active = 0;
        train_start = 1'b1;
        rx_valid = 1'b1;
        rx_data = rotl8(PAT, 5);
        step();
        train_start = 1'b0;
        wait_pulse();
        wait_pulse();
        reset = 1'b1;
        train_start = 1'b1;
        step();
        checks += 5;
        if (bitslip !== 1'b0) begin errors++; $display("FAIL rst_slip_bitslip: got %b expected 0", bitslip); end
        if (align_done !== 1'b0) begin errors++; $display("FAIL rst_slip_done: got %b expected 0", align_done); end
        if (align_err !== 1'b0) begin errors++; $display("FAIL rst_slip_err: got %b expected 0", align_err); end
        if (slip_cnt !== 4'd0) begin errors++; $display("FAIL rst_slip_slip_cnt: got %0d expected 0", slip_cnt); end
        if (rev_sel !== 1'b0) begin errors++; $display("FAIL rst_slip_rev_sel: got %b expected 0", rev_sel); end
        reset = 1'b0;
        train_start = 1'b0;
        rx_data = PAT;
        repeat (25) begin
            step();
            if (bitslip || align_done) active++;
        end
        checks++;
        if (active != 0) begin errors++; $display("FAIL rst_priority_idle: got %0d active cycles expected 0", active); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_rotated();
        test_exhaust();
        test_reverse();
        test_mismatch_inject();
        test_valid_gap();
        test_random();
        test_restart_in_wait();
        test_reset_in_slip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
